// File: rtl/ysyx_24090003_ifu_prefetch.sv
// rtl/ysyx_24090003_ifu_prefetch.sv - prefetching instruction fetch unit with in-order instruction buffer
//
// Keeps up to DEPTH fetches in flight and buffers returned words with their PCs.
// Ports:
//   cpu_clk, cpu_rs                     clock, asynchronous active-low reset
//   imem_req_valid/ready/addr           fetch request channel toward instruction memory
//   imem_rsp_valid/data/err             in-order response channel, always accepted
//   redirect_valid/pc                   EX-stage redirect; flushes buffer, dooms in-flight fetches
//   inst_valid/ready, inst/pc/err       buffer head toward decode

module ysyx_24090003_ifu_prefetch #(
   parameter int                XLEN     = 32,
   parameter logic [XLEN-1:0]   RESET_PC = 'h8000_0000,
   parameter int                DEPTH    = 4
) (
   input  logic             cpu_clk,
   input  logic             cpu_rs,
   output logic             imem_req_valid,
   input  logic             imem_req_ready,
   output logic [XLEN-1:0]  imem_req_addr,
   input  logic             imem_rsp_valid,
   input  logic [31:0]      imem_rsp_data,
   input  logic             imem_rsp_err,
   input  logic             redirect_valid,
   input  logic [XLEN-1:0]  redirect_pc,
   output logic             inst_valid,
   input  logic             inst_ready,
   output logic [31:0]      inst,
   output logic [XLEN-1:0]  inst_pc,
   output logic             inst_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] rsp_pc;
   logic [CW-1:0]   outstanding;
   logic [CW-1:0]   drop_cnt;
   logic [CW-1:0]   count;
   logic [AW-1:0]   head;
   logic [AW-1:0]   tail;

   logic [31:0]     buf_inst [DEPTH];
   logic [XLEN-1:0] buf_pc   [DEPTH];
   logic            buf_err  [DEPTH];

   logic [CW:0]     in_use;
   logic            can_issue;
   logic            req_fire;
   logic            push;
   logic            pop;
   logic [XLEN-1:0] redirect_aligned;

   // Credits cover both in-flight fetches (doomed ones included) and buffered
   // words, so a response always finds a free slot.
   assign in_use    = {1'b0, outstanding} + {1'b0, count};
   assign can_issue = (in_use < (CW+1)'(DEPTH)) && !redirect_valid;

   // Gated by reset so the request is quiet while the unit is held in reset.
   assign imem_req_valid = can_issue && cpu_rs;
   assign imem_req_addr  = fetch_pc;
   assign req_fire       = imem_req_valid && imem_req_ready;

   assign push = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
   assign pop  = inst_valid && inst_ready && !redirect_valid;

   assign redirect_aligned = redirect_pc & ~XLEN'(3);

   assign inst_valid = (count != '0);
   assign inst       = buf_inst[head];
   assign inst_pc    = buf_pc[head];
   assign inst_err   = buf_err[head];

   always_ff @(posedge cpu_clk or negedge cpu_rs) begin
      if (!cpu_rs) begin
         fetch_pc    <= RESET_PC;
         rsp_pc      <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
         count       <= '0;
         head        <= '0;
         tail        <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            buf_inst[i] <= '0;
            buf_pc[i]   <= RESET_PC;
            buf_err[i]  <= 1'b0;
         end
      end else if (redirect_valid) begin
         fetch_pc    <= redirect_aligned;
         rsp_pc      <= redirect_aligned;
         count       <= '0;
         head        <= tail;
         // A response landing now is consumed here; every other in-flight
         // fetch (already doomed or not) must be dropped when it returns.
         drop_cnt    <= drop_cnt + outstanding - CW'(imem_rsp_valid);
         outstanding <= outstanding - CW'(imem_rsp_valid);
      end else begin
         if (req_fire) begin
            fetch_pc <= fetch_pc + XLEN'(4);
         end
         outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
         if (imem_rsp_valid && (drop_cnt != '0)) begin
            drop_cnt <= drop_cnt - CW'(1);
         end
         if (push) begin
            buf_inst[tail] <= imem_rsp_data;
            buf_pc[tail]   <= rsp_pc;
            buf_err[tail]  <= imem_rsp_err;
            tail           <= tail + AW'(1);
            rsp_pc         <= rsp_pc + XLEN'(4);
         end
         if (pop) begin
            head <= head + AW'(1);
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

endmodule

// File: tb/tb_ysyx_24090003_ifu_prefetch.sv
// tb/tb_ysyx_24090003_ifu_prefetch.sv - directed self-checking bench for the prefetching fetch unit

module tb_ysyx_24090003_ifu_prefetch;

   localparam int DEPTH = 4;

   logic        cpu_clk = 1'b0;
   logic        cpu_rs  = 1'b1;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        imem_rsp_err;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_err;

   int          lat;
   logic [31:0] err_addr;
   logic [31:0] pend_addr [$];
   int          pend_due  [$];
   int          cyc;
   int          n_issued;
   int          max_cnt;
   int          n_chk;
   int          n_pass;

   ysyx_24090003_ifu_prefetch #(
      .XLEN     (32),
      .RESET_PC (32'h8000_0000),
      .DEPTH    (DEPTH)
   ) dut (
      .cpu_clk        (cpu_clk),
      .cpu_rs         (cpu_rs),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .imem_rsp_err   (imem_rsp_err),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .inst_err       (inst_err)
   );

   always #5 cpu_clk = ~cpu_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic mem_clear();
      pend_addr.delete();
      pend_due.delete();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      imem_rsp_err   = 1'b0;
   endtask

   // One clock cycle: sample the handshakes mid-cycle, then update the
   // in-order memory model and drive the response for the new cycle.
   task automatic tick();
      logic        hs;
      logic        rv;
      logic [31:0] a;
      @(negedge cpu_clk);
      hs = imem_req_valid && imem_req_ready;
      rv = imem_rsp_valid;
      a  = imem_req_addr;
      @(posedge cpu_clk);
      #1;
      if (rv && pend_addr.size() > 0) begin
         void'(pend_addr.pop_front());
         void'(pend_due.pop_front());
      end
      if (hs && cpu_rs) begin
         pend_addr.push_back(a);
         pend_due.push_back(cyc + lat);
         n_issued++;
      end
      cyc++;
      if (cpu_rs && pend_addr.size() > 0 && pend_due[0] <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = ~pend_addr[0];
         imem_rsp_err   = (pend_addr[0] == err_addr);
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = '0;
         imem_rsp_err   = 1'b0;
      end
      if (int'(dut.count) > max_cnt) max_cnt = int'(dut.count);
   endtask

   task automatic do_reset(input int new_lat, input logic rdy);
      cpu_rs         = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      inst_ready     = rdy;
      lat            = new_lat;
      mem_clear();
      tick();
      tick();
      n_issued = 0;
      cpu_rs   = 1'b1;
      #1;
   endtask

   initial begin
      n_chk = 0; n_pass = 0; cyc = 0; n_issued = 0; max_cnt = 0;
      lat = 1; err_addr = 32'hFFFF_FFFF;
      imem_req_ready = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      inst_ready     = 1'b1;
      mem_clear();

      #1 cpu_rs = 1'b0;
      #1;
      check("rst_req_valid", 32'(imem_req_valid), 0);
      check("rst_req_addr",  imem_req_addr, 32'h8000_0000);
      check("rst_inst_valid", 32'(inst_valid), 0);
      check("rst_inst",      inst, 0);
      check("rst_inst_pc",   inst_pc, 32'h8000_0000);
      check("rst_inst_err",  32'(inst_err), 0);

      // Reset release and 1-cycle streaming
      do_reset(1, 1'b1);
      check("rel_req_valid", 32'(imem_req_valid), 1);
      check("rel_req_addr",  imem_req_addr, 32'h8000_0000);
      tick();
      check("st_valid_c1", 32'(inst_valid), 0);
      check("st_addr_c1",  imem_req_addr, 32'h8000_0004);
      for (int k = 0; k < 6; k++) begin
         tick();
         check("st_valid", 32'(inst_valid), 1);
         check("st_pc",    inst_pc, 32'h8000_0000 + 32'(4 * k));
         check("st_inst",  inst, ~(32'h8000_0000 + 32'(4 * k)));
         check("st_addr",  imem_req_addr, 32'h8000_0000 + 32'(4 * (k + 2)));
      end

      // Backpressure: credits run out at DEPTH
      do_reset(1, 1'b0);
      max_cnt = 0;
      for (int k = 0; k < 8; k++) tick();
      check("bp_issued",    32'(n_issued), 4);
      check("bp_req_valid", 32'(imem_req_valid), 0);
      check("bp_head_pc",   inst_pc, 32'h8000_0000);
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      check("bp_pop_req_valid", 32'(imem_req_valid), 1);
      for (int k = 0; k < 5; k++) tick();
      check("bp_issued_after_pop", 32'(n_issued), 5);
      check("bp_req_valid_after",  32'(imem_req_valid), 0);
      check("bp_head_pc_after",    inst_pc, 32'h8000_0004);
      check("bp_no_overflow",      32'(max_cnt <= DEPTH), 1);

      // Redirect with three fetches in flight, 3-cycle memory
      do_reset(3, 1'b1);
      tick(); tick(); tick();
      check("rd_outstanding", 32'(dut.outstanding), 3);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0100;
      #1;
      check("rd_no_req", 32'(imem_req_valid), 0);
      tick();
      redirect_valid = 1'b0;
      #1;
      check("rd_drop_cnt", 32'(dut.drop_cnt), 2);
      check("rd_new_addr", imem_req_addr, 32'h8000_0100);
      check("rd_new_valid", 32'(imem_req_valid), 1);
      for (int i = 0; i < 20 && !inst_valid; i++) tick();
      check("rd_first_valid", 32'(inst_valid), 1);
      check("rd_first_pc",    inst_pc, 32'h8000_0100);
      check("rd_drop_done",   32'(dut.drop_cnt), 0);
      tick();
      check("rd_second_pc",   inst_pc, 32'h8000_0104);

      // Redirect coincident with a response and a pop, 2-cycle memory
      do_reset(2, 1'b1);
      tick(); tick(); tick();
      check("co_head_valid",  32'(inst_valid), 1);
      check("co_outstanding", 32'(dut.outstanding), 2);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0200;
      #1;
      check("co_no_req", 32'(imem_req_valid), 0);
      tick();
      redirect_valid = 1'b0;
      #1;
      check("co_flushed",     32'(inst_valid), 0);
      check("co_drop_cnt",    32'(dut.drop_cnt), 1);
      check("co_outstanding_after", 32'(dut.outstanding), 1);
      for (int i = 0; i < 20 && !inst_valid; i++) tick();
      check("co_first_pc",   inst_pc, 32'h8000_0200);
      check("co_first_inst", inst, ~32'h8000_0200);

      // Misaligned redirect followed by a faulting fetch
      do_reset(1, 1'b0);
      err_addr = 32'h8000_0010;
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0013;
      tick();
      redirect_valid = 1'b0;
      #1;
      check("mis_addr",     imem_req_addr, 32'h8000_0010);
      check("mis_drop_cnt", 32'(dut.drop_cnt), 0);
      for (int i = 0; i < 20 && !inst_valid; i++) tick();
      check("mis_pc",  inst_pc, 32'h8000_0010);
      check("mis_err", 32'(inst_err), 1);
      inst_ready = 1'b1;
      tick();
      check("mis_next_pc",  inst_pc, 32'h8000_0014);
      check("mis_next_err", 32'(inst_err), 0);
      err_addr = 32'hFFFF_FFFF;

      // Asynchronous reset with the buffer half full
      do_reset(1, 1'b0);
      tick(); tick(); tick();
      check("ar_count_before", 32'(dut.count), 2);
      #2;
      cpu_rs = 1'b0;
      mem_clear();
      #1;
      check("ar_inst_valid", 32'(inst_valid), 0);
      check("ar_req_valid",  32'(imem_req_valid), 0);
      tick();
      cpu_rs = 1'b1;
      #1;
      check("ar_restart_addr",  imem_req_addr, 32'h8000_0000);
      check("ar_restart_valid", 32'(imem_req_valid), 1);
      tick(); tick();
      check("ar_restart_pc", inst_pc, 32'h8000_0000);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/ysyx_24090003_ifu_prefetch.md
# ysyx_24090003_ifu_prefetch

Parametrised prefetching instruction fetch unit. It sits between the instruction memory port and the decode stage, and replaces the single-register fetch path. It keeps up to DEPTH requests in flight toward memory and buffers returned instructions, with their PCs, in an in-order FIFO. EX-stage redirects flush the buffer and silently drop stale responses.

## Interface
- XLEN, 32: PC/address width.
- RESET_PC, 32'h8000_0000: first fetch address after reset.
- DEPTH, 4: instruction buffer entries and maximum credits; power of two, ≥2.

- cpu_clk  in  1  clock; all state updates on the rising edge.
- cpu_rs  in  1  reset; asynchronous, active-low.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  XLEN  fetch address, word aligned.
- imem_rsp_valid  in  1  response valid; always accepted, in request order.
- imem_rsp_data  in  32  instruction word.
- imem_rsp_err  in  1  access fault for this response.
- redirect_valid  in  1  EX redirect (branch taken, jump or trap).
- redirect_pc  in  XLEN  redirect target; bits [1:0] are ignored and treated as 0.
- inst_valid  out  1  buffer head is valid.
- inst_ready  in  1  decode consumes the head.
- inst  out  32  head instruction.
- inst_pc  out  XLEN  PC of the head instruction.
- inst_err  out  1  fault flag of the head instruction.

## Operation
- **State**
  - fetch_pc: next request address.
  - rsp_pc: PC assigned to the next kept response.
  - outstanding: requests in flight, including doomed ones.
  - drop_cnt: in-flight responses to discard.
  - FIFO: DEPTH × {inst, pc, err}, with head/tail pointers and count.
  - Counters are $clog2(DEPTH)+1 bits wide.
- **Credit**
  - can_issue = (outstanding + count < DEPTH) && !redirect_valid.
  - imem_req_valid = can_issue; imem_req_addr = fetch_pc.
- **Request handshake** (req_valid && req_ready)
  - fetch_pc += 4, modulo 2^XLEN wrap.
  - outstanding += 1.
- **Response**
  - Every response decrements outstanding.
  - If drop_cnt ≠ 0: discard the response and decrement drop_cnt.
  - Otherwise: push {rsp_data, rsp_pc, rsp_err} and rsp_pc += 4.
- **Pop**
  - inst_valid && inst_ready && !redirect_valid advances the head.
  - Push and pop in the same cycle leave count unchanged.
  - Overflow is impossible by construction; the bench asserts it.
- **Redirect** (highest priority)
  - fetch_pc and rsp_pc are loaded with {redirect_pc[XLEN-1:2], 2'b00}.
  - FIFO flushed: count = 0, head = tail.
  - A response arriving in the redirect cycle is discarded.
  - drop_cnt ← drop_cnt + outstanding − rsp_valid (still-live in-flight responses become doomed).
  - outstanding ← outstanding − rsp_valid.
  - No request is issued in the redirect cycle.
  - Back-to-back redirects: the last one wins. Doomed counts accumulate correctly because outstanding already includes them.
- **Fault**
  - imem_rsp_err is carried to inst_err unchanged; fetching continues.
  - Decode or EX decides the trap and redirects.

## Timing
- **Reset** (asynchronous on cpu_rs low, release synchronised by the system)
  - fetch_pc = rsp_pc = RESET_PC.
  - outstanding = drop_cnt = count = 0.
  - imem_req_valid = 0, inst_valid = 0, inst = 0, inst_pc = RESET_PC, inst_err = 0.
  - imem_req_addr = RESET_PC.
- **First cycle after reset release:** imem_req_valid = 1, addr = 0x8000_0000.
- **Reset mid-operation:** all state returns to reset values immediately. Memory must also be reset; responses after reset are not expected.
- **Memory contract:** a response arrives ≥1 cycle after its request handshake, never in the same cycle.
- **Push-to-output latency:** a kept response is visible on inst_valid/inst in the cycle after imem_rsp_valid.
- **Throughput:** with a 1-cycle memory and inst_ready held high, steady state is 1 instruction per cycle.
- **Redirect latency:** the new request issues in the cycle after redirect_valid. The first redirect instruction appears no earlier than 2 cycles after the redirect cycle plus memory latency.
- **Outputs:** inst, inst_pc and inst_err are driven from FIFO storage (registered), with no combinational path from the imem_rsp_* inputs.

## Test plan
- **Reset and stream:** release reset; 1-cycle memory returning addr-derived data; inst_ready = 1.
  - Requests go to 0x8000_0000, _0004, _0008, ….
  - inst_pc follows the same sequence.
  - inst_valid first asserts 2 cycles after reset release, then holds high every cycle.
- **Backpressure:** inst_ready = 0 with DEPTH = 4.
  - Exactly 4 requests issue, then req_valid = 0.
  - After 1 pop, exactly one new request issues.
  - No FIFO overflow.
- **Redirect with in-flight requests:** 3-cycle memory latency, 3 outstanding; redirect to 0x8000_0100.
  - The 3 stale responses are dropped.
  - The next inst_pc is 0x8000_0100.
  - No stale PC is ever presented.
- **Redirect coincident with response and pop:** response valid, inst_ready = 1 and redirect_valid in the same cycle.
  - The response is discarded and the pop is ignored.
  - drop_cnt equals the remaining in-flight count.
- **Misaligned redirect and fault:** redirect_pc = 0x8000_0013, then a response with imem_rsp_err = 1.
  - Fetch address is 0x8000_0010.
  - Head shows inst_pc = 0x8000_0010 and inst_err = 1.
  - The next instruction is at 0x8000_0014 with inst_err = 0.
- **Async reset mid-stream:** drop cpu_rs with the FIFO half full.
  - inst_valid and req_valid fall without waiting for a clock edge.
  - After release, fetch restarts at 0x8000_0000.
